ddr_input_reporter: RTL
=======================

Name: ddr_input_reporter

Overview:
Parametrised successor to the DDR pad-to-UART top level. Samples NUM_BTN raw pad/button inputs, debounces them and turns press/release edges into timestamped event frames. Frames are buffered in a FIFO and handed to the existing uart_top multi-byte transmitter through its i_tx_data/i_tx_stb/o_tx_busy handshake. Host command bytes arriving from uart_top RX pause, resume or clear reporting.

Parameters:
NUM_BTN, 5, number of button inputs (1..32)
DEB_CYCLES, 100000, stable cycles required before a debounced level changes
TICK_DIV, 100000, clk cycles per timestamp tick (1 ms at 100 MHz)
TS_WIDTH, 16, timestamp width in bits; must be a multiple of 8
FIFO_DEPTH, 8, event FIFO entries; power of 2, >=2
HB_TICKS, 1000, heartbeat period in ticks (used only with HEARTBEAT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_raw  in  NUM_BTN  raw asynchronous button levels, 1 = pressed
rx_data  in  8  command byte from uart_top o_rx_data
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_busy  in  1  uart_top o_tx_busy
tx_data  out  FRAME_W  frame to uart_top i_tx_data; FRAME_W = 16+TS_WIDTH
tx_valid  out  1  one-cycle frame strobe to uart_top i_tx_stb
btn_state  out  NUM_BTN  debounced levels
overflow  out  1  sticky FIFO-overflow flag

Behaviour:
- Reset values: tx_data=0, tx_valid=0, btn_state=0, overflow=0, timestamp=0, enabled=1, FIFO empty, FSM IDLE.
- Sync: each btn_raw bit passes a 2-FF synchroniser.
- Debounce: per-bit counter. Clear while the synced value equals btn_state. Otherwise increment; on reaching DEB_CYCLES-1, btn_state flips and the counter clears.
- Edge: a 0->1 flip sets that bit in pend_press; a 1->0 flip sets it in pend_rel. An edge on a bit whose pending flag is already set overwrites that flag; no double count.
- Arbiter: each cycle, picks the lowest-index set bit, presses before releases. Builds the entry {type=0, press, overflow, idx[4:0], timestamp}, clears that pending bit, and pushes. One push per cycle max.
- While enabled=0, edges update btn_state but set no pending bits. Pause also clears all pending bits.
- FIFO: push when full drops the entry and sets overflow, which stays set until a 'C' command or reset. Simultaneous push+pop when full is legal; no drop.
- Timestamp: prescaler counts 0..TICK_DIV-1; on wrap, timestamp increments modulo 2^TS_WIDTH.
- Frame layout, MSB first: [FRAME_W-1 -: 8] = 8'hA5 sync; next 8 = {type, press, overflow, idx[4:0]}; low TS_WIDTH = timestamp.
- TX FSM:
  - IDLE: FIFO non-empty and tx_busy=0 -> pop into tx_data, go to SEND.
  - SEND: tx_valid=1 for exactly one cycle -> WAIT_HI.
  - WAIT_HI: tx_busy=1 -> WAIT_LO.
  - WAIT_LO: tx_busy=0 -> IDLE.
  - tx_data holds its value from pop until the next pop.
- Commands, acted on in the cycle after rx_valid:
  - 8'h53 'S': enabled=1.
  - 8'h50 'P': enabled=0.
  - 8'h43 'C': overflow=0, timestamp=0, prescaler=0.
  - Other bytes: ignored.
  - Queued FIFO entries still transmit while paused.
- Reset mid-frame: all state clears immediately; uart_top finishes any byte already in flight independently.

Optional Feature:
HEARTBEAT_EN
- Defined: every HB_TICKS ticks, while enabled, a heartbeat entry {type=1, press=0, overflow, idx=0, timestamp} is pushed. The heartbeat has lower priority than button events; it stays pending until a free push slot.
- Undefined: no heartbeat logic is synthesised; type bit is always 0.

Decomposition:
- Shared package ddr_pkg: SYNC_BYTE=8'hA5, command codes CMD_START/CMD_PAUSE/CMD_CLEAR, frame field offsets, TX FSM state encoding.
- One sub-module: ddr_debounce, a single-bit synchroniser + debouncer instantiated NUM_BTN times via generate.
- FIFO stays inline.

Test Plan:
- Reset, DEB_CYCLES=4, TICK_DIV=4: hold btn_raw[2]=1 for 10 cycles -> btn_state[2] rises exactly once; one frame tx_data=16'hA5_42 concatenated with the timestamp; tx_valid high exactly 1 cycle.
- Pulse btn_raw[1]=1 for 2 cycles (< DEB_CYCLES) -> no btn_state change, no tx_valid.
- Press btn 0 and btn 3 in the same cycle -> two frames: idx 0 first, then idx 3; the second strobe only after tx_busy falls.
- tx_busy held high, 10 distinct edges with FIFO_DEPTH=8 -> 8 frames sent after release; overflow=1 and flag bit set in later frames. Send 8'h43 -> overflow=0, timestamp restarts at 0.
- Send 8'h50, press btn 4 -> btn_state[4]=1, no frame. Send 8'h53, release btn 4 -> release frame, flags=8'h04.
- With HEARTBEAT_EN, HB_TICKS=3 -> heartbeat frame with flags=8'h80 every 3 ticks; none while paused.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR input reporter: frame layout, host command
// codes and the TX handshake state encoding.
package ddr_pkg;

    // Frame header fields, MSB first: sync byte, then the flags byte
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         SYNC_W    = 8;
    localparam int         FLAGS_W   = 8;
    localparam int         HDR_W     = SYNC_W + FLAGS_W;
    localparam int         IDX_W     = 5;

    // Host command bytes received through uart_top RX
    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_PAUSE = 8'h50;
    localparam logic [7:0] CMD_CLEAR = 8'h43;

    // Handshake with the uart_top transmitter
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAIT_HI,
        TX_WAIT_LO
    } tx_state_e;

    // Flags byte: {type, press, overflow, idx[4:0]}
    function automatic logic [FLAGS_W-1:0] make_flags(
        input logic             ev_type,
        input logic             press,
        input logic             ovf,
        input logic [IDX_W-1:0] idx
    );
        return {ev_type, press, ovf, idx};
    endfunction

endpackage

// File: rtl/ddr_debounce.sv
// Single-bit two-flop synchroniser followed by a stable-count debouncer.
// The level only changes after the synchronised input has disagreed with it
// for DEB_CYCLES consecutive cycles; rise/fall pulse in the cycle the
// debounced level changes.
module ddr_debounce #(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Synchronise the raw pad and count how long it has disagreed with the level
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, debounce counter and edge pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ddr_input_reporter.sv
// Debounces NUM_BTN button inputs, turns press/release edges into
// timestamped frames, buffers them in a FIFO and hands them to uart_top.
// Host bytes 'S'/'P'/'C' resume, pause and clear reporting.
// Optional feature macro: HEARTBEAT_EN (periodic heartbeat frames).
module ddr_input_reporter
    import ddr_pkg::*;
#(
    parameter int NUM_BTN    = 5,
    parameter int DEB_CYCLES = 100000,
    parameter int TICK_DIV   = 100000,
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int HB_TICKS   = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_BTN-1:0]        btn_raw,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    input  logic                      tx_busy,
    output logic [HDR_W+TS_WIDTH-1:0] tx_data,
    output logic                      tx_valid,
    output logic [NUM_BTN-1:0]        btn_state,
    output logic                      overflow
);

    localparam int FRAME_W = HDR_W + TS_WIDTH;
    localparam int ENTRY_W = FLAGS_W + TS_WIDTH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Per-button synchroniser + debouncer
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] deb_level;
    logic [NUM_BTN-1:0] deb_rise;
    logic [NUM_BTN-1:0] deb_fall;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
        ddr_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[gi]),
            .level (deb_level[gi]),
            .rise  (deb_rise[gi]),
            .fall  (deb_fall[gi])
        );
    end

    assign btn_state = deb_level;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                 cmd_valid_q, cmd_valid_d;
    logic [7:0]           cmd_byte_q, cmd_byte_d;
    logic                 cmd_start, cmd_pause, cmd_clear;
    logic                 enabled_q, enabled_d;
    logic [PRE_W-1:0]     presc_q, presc_d;
    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic                 tick;
    logic [NUM_BTN-1:0]   pend_press_q, pend_press_d;
    logic [NUM_BTN-1:0]   pend_rel_q, pend_rel_d;
    logic [NUM_BTN-1:0]   sel_vec, sel_mask;
    logic [IDX_W-1:0]     sel_idx;
    logic                 press_hit, rel_hit;
    logic                 push_req;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic                 fifo_full, fifo_empty;
    logic                 push_ok, pop;
    logic                 overflow_q, overflow_d;
    tx_state_e            state_q, state_d;
    logic [FRAME_W-1:0]   tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;

`ifdef HEARTBEAT_EN
    localparam int               HB_W   = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;
    localparam logic [HB_W-1:0]  HB_MAX = HB_W'(HB_TICKS - 1);

    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic            hb_pend_q, hb_pend_d;
    logic            hb_fire;
    logic            hb_grant;
`else
    logic            unused_hb_ticks;
    assign unused_hb_ticks = ^HB_TICKS;
`endif

    // Capture a host byte so that it takes effect in the following cycle
    always_comb begin
        cmd_valid_d = rx_valid;
        cmd_byte_d  = rx_valid ? rx_data : cmd_byte_q;
        cmd_start   = cmd_valid_q && (cmd_byte_q == CMD_START);
        cmd_pause   = cmd_valid_q && (cmd_byte_q == CMD_PAUSE);
        cmd_clear   = cmd_valid_q && (cmd_byte_q == CMD_CLEAR);
    end

    // Reporting enable plus the tick prescaler and timestamp counter
    always_comb begin
        enabled_d = enabled_q;
        if (cmd_start) enabled_d = 1'b1;
        if (cmd_pause) enabled_d = 1'b0;

        tick    = (presc_q == PRE_MAX);
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
        ts_d    = tick ? ts_q + TS_WIDTH'(1) : ts_q;
        if (cmd_clear) begin
            presc_d = '0;
            ts_d    = '0;
        end
    end

`ifdef HEARTBEAT_EN
    // Heartbeat period counter; a fired heartbeat waits for a free push slot
    always_comb begin
        hb_cnt_d = hb_cnt_q;
        hb_fire  = 1'b0;
        if (tick) begin
            if (hb_cnt_q == HB_MAX) begin
                hb_cnt_d = '0;
                hb_fire  = 1'b1;
            end else begin
                hb_cnt_d = hb_cnt_q + HB_W'(1);
            end
        end
        if (cmd_clear) hb_cnt_d = '0;

        hb_pend_d = hb_pend_q;
        if (hb_grant)             hb_pend_d = 1'b0;
        if (hb_fire && enabled_q) hb_pend_d = 1'b1;
        if (cmd_pause)            hb_pend_d = 1'b0;
    end
`endif

    // Arbiter: lowest pending press first, then releases; one push per cycle
    always_comb begin
        press_hit = |pend_press_q;
        rel_hit   = |pend_rel_q;
        sel_vec   = press_hit ? pend_press_q : pend_rel_q;
        sel_mask  = sel_vec & (~sel_vec + NUM_BTN'(1));
        sel_idx   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (sel_mask[i]) sel_idx = sel_idx | IDX_W'(i);
        end

        push_req   = 1'b0;
        push_entry = '0;
`ifdef HEARTBEAT_EN
        hb_grant   = 1'b0;
`endif
        pend_press_d = pend_press_q;
        pend_rel_d   = pend_rel_q;

        if (press_hit || rel_hit) begin
            push_req   = 1'b1;
            push_entry = {make_flags(1'b0, press_hit, overflow_q, sel_idx), ts_q};
            if (press_hit) pend_press_d = pend_press_q & ~sel_mask;
            else           pend_rel_d   = pend_rel_q & ~sel_mask;
        end
`ifdef HEARTBEAT_EN
        else if (hb_pend_q) begin
            push_req   = 1'b1;
            push_entry = {make_flags(1'b1, 1'b0, overflow_q, '0), ts_q};
            hb_grant   = 1'b1;
        end
`endif

        if (enabled_q) begin
            pend_press_d = pend_press_d | deb_rise;
            pend_rel_d   = pend_rel_d | deb_fall;
        end
        if (cmd_pause) begin
            pend_press_d = '0;
            pend_rel_d   = '0;
        end
    end

    // Event FIFO bookkeeping; a push into a full FIFO without a pop is dropped
    always_comb begin
        fifo_full  = (count_q == CNT_FULL);
        fifo_empty = (count_q == '0);
        push_ok    = push_req && (!fifo_full || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop)      count_d = count_q + (PTR_W + 1)'(1);
        else if (!push_ok && pop) count_d = count_q - (PTR_W + 1)'(1);

        overflow_d = overflow_q;
        if (cmd_clear) overflow_d = 1'b0;
        if (push_req && !push_ok) overflow_d = 1'b1;
    end

    // TX handshake: pop into tx_data, strobe once, then follow tx_busy high and low
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop        = 1'b1;
                    tx_data_d  = {SYNC_BYTE, mem_q[rd_ptr_q]};
                    tx_valid_d = 1'b1;
                    state_d    = TX_SEND;
                end
            end
            TX_SEND:    state_d = TX_WAIT_HI;
            TX_WAIT_HI: if (tx_busy)  state_d = TX_WAIT_LO;
            TX_WAIT_LO: if (!tx_busy) state_d = TX_IDLE;
            default:    state_d = TX_IDLE;
        endcase
    end

    // Control, timestamp, pending-event and TX registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= '0;
            enabled_q    <= 1'b1;
            presc_q      <= '0;
            ts_q         <= '0;
            pend_press_q <= '0;
            pend_rel_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            state_q      <= TX_IDLE;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
        end else begin
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            enabled_q    <= enabled_d;
            presc_q      <= presc_d;
            ts_q         <= ts_d;
            pend_press_q <= pend_press_d;
            pend_rel_q   <= pend_rel_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef HEARTBEAT_EN
    // Heartbeat counter and pending flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q  <= '0;
            hb_pend_q <= 1'b0;
        end else begin
            hb_cnt_q  <= hb_cnt_d;
            hb_pend_q <= hb_pend_d;
        end
    end
`endif

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign overflow = overflow_q;

endmodule
